fetch_controller: RTL

Sequencing controller for the instruction-fetch stage of the pipelined MIPS. It loads a program word-by-word into instruction memory, then runs it continuously or one clock at a time by gating the PC update. It detects the halt word, drains the pipeline, and reports status. It sits between the debug/UART command unit and `instruction_fetch` (PC enable, PC clear, instruction-RAM write port).

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_controller_if.sv | 41 ++++
 rtl/load_pointer.sv | 31 +++
 rtl/fetch_controller.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-stage control logic:
// the fetch controller state encoding and the program constants.
package mips_pkg;

  typedef enum logic [2:0] {
    FC_IDLE  = 3'd0,
    FC_LOAD  = 3'd1,
    FC_RUN   = 3'd2,
    FC_STEP  = 3'd3,
    FC_DRAIN = 3'd4,
    FC_HALT  = 3'd5
  } fc_state_t;

  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam int          ADDR_W_DEFAULT = 11;

endpackage

// File: rtl/fetch_controller_if.sv
// Command, program-load and fetch-control signals between the debug unit,
// the fetch controller and instruction_fetch.
interface fetch_controller_if
  import mips_pkg::*;
#(
  parameter int len    = 32,
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic              in_cmd_load;
  logic              in_cmd_run;
  logic              in_cmd_step;
  logic              in_load_valid;
  logic [len-1:0]    in_load_data;
  logic [len-1:0]    in_instruction;
  logic              in_stall;
  logic              out_pc_enable;
  logic              out_pc_clear;
  logic              out_mem_we;
  logic [ADDR_W-1:0] out_mem_addr;
  logic [len-1:0]    out_mem_data;
  logic              out_running;
  logic              out_halted;
  logic              out_step_done;
  logic [len-1:0]    out_cycle_count;

  modport master (
    output in_cmd_load, in_cmd_run, in_cmd_step, in_load_valid, in_load_data,
           in_instruction, in_stall,
    input  out_pc_enable, out_pc_clear, out_mem_we, out_mem_addr, out_mem_data,
           out_running, out_halted, out_step_done, out_cycle_count
  );

  modport slave (
    input  in_cmd_load, in_cmd_run, in_cmd_step, in_load_valid, in_load_data,
           in_instruction, in_stall,
    output out_pc_enable, out_pc_clear, out_mem_we, out_mem_addr, out_mem_data,
           out_running, out_halted, out_step_done, out_cycle_count
  );

endinterface

// File: rtl/load_pointer.sv
// Instruction-RAM write pointer for program load: clear, increment, and a
// terminal flag on the last address so the caller can stop without wrapping.
module load_pointer #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_terminal
);

  logic [ADDR_W-1:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  assign o_ptr      = r_ptr;
  assign o_terminal = &r_ptr;

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: loads a program into instruction RAM, then runs or
// single-steps it by gating the PC, drains the pipeline on the halt word.
module fetch_controller
  import mips_pkg::*;
#(
  parameter int             len       = 32,
  parameter int             ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [len-1:0] HALT_WORD = mips_pkg::HALT_WORD,
  parameter int             DRAIN     = 4
) (
  input logic               clk,
  input logic               reset,
  fetch_controller_if.slave bus
);

  localparam int DRAIN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  fc_state_t          r_state;
  fc_state_t          w_next;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [len-1:0]     r_cycle_count;
  logic               r_pc_clear;
  logic               r_step_done;

  logic               w_accept_load;
  logic               w_mem_we;
  logic               w_ptr_inc;
  logic               w_pc_enable;
  logic               w_running;
  logic               w_is_halt;
  logic               w_drain_done;
  logic [ADDR_W-1:0]  w_ptr;
  logic               w_ptr_last;

  load_pointer #(.ADDR_W(ADDR_W)) u_load_pointer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_accept_load),
    .i_inc      (w_ptr_inc),
    .o_ptr      (w_ptr),
    .o_terminal (w_ptr_last)
  );

  assign w_is_halt    = (bus.in_instruction == HALT_WORD);
  assign w_drain_done = (r_drain_cnt == DRAIN_W'(DRAIN - 1));
  assign w_running    = (r_state == FC_RUN) || (r_state == FC_STEP) || (r_state == FC_DRAIN);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next        = r_state;
    w_accept_load = 1'b0;
    w_mem_we      = 1'b0;
    w_ptr_inc     = 1'b0;
    w_pc_enable   = 1'b0;
    case (r_state)
      FC_IDLE: begin
        if (bus.in_cmd_load) begin
          w_next        = FC_LOAD;
          w_accept_load = 1'b1;
        end else if (bus.in_cmd_run) begin
          w_next = FC_RUN;
        end else if (bus.in_cmd_step) begin
          w_next = FC_STEP;
        end
      end
      FC_LOAD: begin
        if (bus.in_load_valid) begin
          w_mem_we  = 1'b1;
          w_ptr_inc = !w_ptr_last;
          if (bus.in_load_data == HALT_WORD || w_ptr_last) w_next = FC_IDLE;
        end
      end
      FC_RUN: begin
        if (w_is_halt) w_next = FC_DRAIN;
        else           w_pc_enable = !bus.in_stall;
      end
      FC_STEP: begin
        // The halt word wins over a stall so the PC can never step past it.
        if (w_is_halt) begin
          w_next = FC_DRAIN;
        end else if (!bus.in_stall) begin
          w_pc_enable = 1'b1;
          w_next      = FC_IDLE;
        end
      end
      FC_DRAIN: begin
        if (w_drain_done) w_next = FC_HALT;
      end
      FC_HALT: begin
        if (bus.in_cmd_load) begin
          w_next        = FC_LOAD;
          w_accept_load = 1'b1;
        end
      end
      default: w_next = FC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= FC_IDLE;
      r_drain_cnt   <= '0;
      r_cycle_count <= '0;
      r_pc_clear    <= 1'b0;
      r_step_done   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pc_clear  <= w_accept_load;
      r_step_done <= (r_state == FC_STEP) && (w_next == FC_IDLE);
      r_drain_cnt <= (r_state == FC_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
      if (w_accept_load)  r_cycle_count <= '0;
      else if (w_running) r_cycle_count <= r_cycle_count + len'(1);
    end
  end

  assign bus.out_pc_enable   = w_pc_enable;
  assign bus.out_pc_clear    = r_pc_clear;
  assign bus.out_mem_we      = w_mem_we;
  assign bus.out_mem_addr    = w_ptr;
  assign bus.out_mem_data    = w_mem_we ? bus.in_load_data : '0;
  assign bus.out_running     = w_running;
  assign bus.out_halted      = (r_state == FC_HALT);
  assign bus.out_step_done   = r_step_done;
  assign bus.out_cycle_count = r_cycle_count;

endmodule
